hc138_sel_ctrl: RTL
===================

# hc138_sel_ctrl

Round-robin chip-select scheduler that shares the 74HC138 3-to-8 decoder (module `hc138`) among eight requesters. It arbitrates the requests, drives the decoder's 3-bit address and 3-bit enable group, and sequences each selection as setup, active and dead-time phases, so decoder outputs never glitch between two targets. It sits between the peripheral-request logic and the `hc138` instance.

## Interface
Parameters:
- `GAP_CYCLES`, default 2: dead cycles, decoder disabled, after each selection; legal range is 1–15.
- `HOLD_MAX`, default 16: maximum ACTIVE cycles per grant when the timeout is compiled in; legal range is 1–255.

Ports:
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `req`  input  8  request per target; bit i is asserted and held until served.
- `addr`  output  3  decoder select input (`DateA` of `hc138`), registered.
- `enable`  output  3  decoder enable group {G1, G2A_n, G2B_n}, registered.
  - 3'b100 enables the decoder.
  - 3'b011 disables it.
- `gnt`  output  8  one-hot copy of the current selection, asserted only in ACTIVE.
- `busy`  output  1  high in SETUP, ACTIVE and GAP.
- `timeout`  output  1  one-cycle pulse when a grant is force-ended.

## Operation
- Reset values:
  - `addr`=0, `enable`=3'b011, `gnt`=0, `busy`=0, `timeout`=0.
  - State = IDLE; round-robin pointer `last`=7, so index 0 has top priority first.
- States: IDLE → SETUP → ACTIVE → GAP → IDLE.
- IDLE:
  - If `req`≠0, select the winner: the first set bit searched from `last`+1 upward, wrapping 7→0.
  - Load `addr` and `last` with the winner and go to SETUP.
  - `enable` stays 3'b011.
- SETUP:
  - Lasts exactly one cycle; `addr` is stable and `enable`=3'b011.
  - Next state is ACTIVE, with `enable`←3'b100 and `gnt`←1<<`addr`.
- ACTIVE:
  - Holds while `req[addr]`=1.
  - When `req[addr]`=0 is sampled, go to GAP: `enable`←3'b011, `gnt`←0, gap counter loaded with `GAP_CYCLES`-1.
- GAP:
  - `addr` is held and the counter decrements.
  - When the counter reaches 0, go to IDLE.
- Requests from other indices arriving during SETUP, ACTIVE or GAP are not lost; they are evaluated at the next IDLE.
- A request that drops during SETUP still gets one ACTIVE cycle, then GAP.
- Fairness: the just-served index has lowest priority at the next arbitration.
  - Example: with `req`=8'hFF held, grants go 0,1,2,…,7,0.
- `rst_n` asserted mid-operation: all outputs go immediately (asynchronously) to their reset values; the pointer returns to 7.

## Timing
- Request to enable: `req[i]` rises before edge E0 while in IDLE.
  - Edge E0: `addr`=i.
  - Edge E0+1: `enable`=3'b100 and `gnt[i]`=1.
  - Latency is 2 cycles.
- Release to disable: `req[i]` falls before edge R0; `enable`=3'b011 after R0 (1 cycle).
- Grant-to-grant minimum spacing: GAP (`GAP_CYCLES`), then IDLE (1), then SETUP (1).
  - With default `GAP_CYCLES`=2, `enable` is deasserted for 4 cycles between two grants.
- `addr` never changes while `enable`=3'b100; it changes only on the IDLE→SETUP edge.

## Configuration
- `HC138_SEL_TIMEOUT_EN` defined:
  - An 8-bit hold counter counts ACTIVE cycles.
  - After `HOLD_MAX` ACTIVE cycles with `req[addr]` still 1, the block goes to GAP and pulses `timeout` for one cycle on the same edge.
  - The requester then loses priority under the normal round-robin rules.
- Not defined:
  - The hold counter and the `timeout` logic are absent; `timeout` is tied to 0.
  - ACTIVE lasts until `req[addr]` drops, unbounded.

## Test plan
- Reset: hold `rst_n`=0 with `req`=8'hFF → `addr`=0, `enable`=3'b011, `gnt`=0, `busy`=0. Release reset → first `gnt`=8'h01 two cycles later.
- Single requester: pulse `req`=8'h20 for 5 cycles → `addr`=5. `enable`=3'b100 with `gnt`=8'h20 starts 2 cycles after `req` rises and ends 1 cycle after `req` drops. After 2 GAP cycles, `busy`=0.
- Round-robin: hold `req`=8'h81 and release each grant after 3 ACTIVE cycles → grant order 0,7,0,7. Between grants `enable` is 3'b011 for 4 cycles, and `addr` is stable whenever `enable`=3'b100.
- Late arrival: with `req`=8'h04 active, assert `req[1]` → `req[1]` is served after GAP/IDLE/SETUP. Nothing glitches on `gnt`, and `gnt` is never multi-hot.
- Timeout (macro defined, `HOLD_MAX`=4): hold `req`=8'h03 permanently → `gnt`=8'h01 for 4 cycles with a `timeout` pulse, then `gnt`=8'h02 for 4 cycles, alternating. With the macro undefined, `gnt`=8'h01 persists.
- Reset mid-grant: drop `rst_n` during ACTIVE with `addr`=6 → `enable`=3'b011 and `gnt`=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/hc138_sel_ctrl_if.sv
// Request/select bundle between the peripheral-request logic and the hc138 chip-select scheduler.
// The master modport is the requester side; the slave modport is the scheduler.
interface hc138_sel_ctrl_if;
    logic [7:0] req;
    logic [2:0] addr;
    logic [2:0] enable;
    logic [7:0] gnt;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        input  addr,
        input  enable,
        input  gnt,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        output addr,
        output enable,
        output gnt,
        output busy,
        output timeout
    );
endinterface

// File: rtl/hc138_sel_ctrl.sv
// Round-robin chip-select scheduler for a shared 74HC138 decoder: IDLE -> SETUP -> ACTIVE -> GAP.
// Optional grant timeout is compiled in with the HC138_SEL_TIMEOUT_EN macro.
module hc138_sel_ctrl #(
    parameter int GAP_CYCLES = 2,
    parameter int HOLD_MAX   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    hc138_sel_ctrl_if.slave bus
);
    localparam logic [2:0] EN_ON    = 3'b100;
    localparam logic [2:0] EN_OFF   = 3'b011;
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t     r_state;
    logic [2:0] r_addr;
    logic [2:0] r_last;
    logic [2:0] r_enable;
    logic [7:0] r_gnt;
    logic       r_busy;
    logic [3:0] r_gap_cnt;

    logic [2:0] w_winner;
    logic       w_req_any;
    logic       w_req_sel;
    logic       w_hold_expired;

`ifdef HC138_SEL_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] r_hold_cnt;
    logic       r_timeout;
`endif

    // First set request strictly after the last winner, wrapping 7 -> 0.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
        logic [2:0] idx;
        logic [2:0] win;
        logic       found;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = last + 3'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end else begin
                win   = win;
                found = found;
            end
        end
        return win;
    endfunction

    // Arbitration result and release conditions for the current selection
    always_comb begin
        w_winner  = rr_pick(bus.req, r_last);
        w_req_any = |bus.req;
        w_req_sel = bus.req[r_addr];
`ifdef HC138_SEL_TIMEOUT_EN
        w_hold_expired = (r_hold_cnt == HOLD_LAST);
`else
        w_hold_expired = 1'b0;
`endif
    end

    // Selection sequencer; every decoder-facing output is registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_addr    <= 3'd0;
            r_last    <= 3'd7;
            r_enable  <= EN_OFF;
            r_gnt     <= 8'h00;
            r_busy    <= 1'b0;
            r_gap_cnt <= 4'd0;
`ifdef HC138_SEL_TIMEOUT_EN
            r_hold_cnt <= 8'd0;
            r_timeout  <= 1'b0;
`endif
        end else begin
`ifdef HC138_SEL_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    // addr moves only here, so it is settled a full cycle before enable rises
                    if (w_req_any) begin
                        r_addr  <= w_winner;
                        r_last  <= w_winner;
                        r_busy  <= 1'b1;
                        r_state <= ST_SETUP;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    r_enable <= EN_ON;
                    r_gnt    <= 8'h01 << r_addr;
                    r_state  <= ST_ACTIVE;
`ifdef HC138_SEL_TIMEOUT_EN
                    r_hold_cnt <= 8'd0;
`endif
                end
                ST_ACTIVE: begin
                    if (!w_req_sel || w_hold_expired) begin
                        r_enable  <= EN_OFF;
                        r_gnt     <= 8'h00;
                        r_gap_cnt <= GAP_LOAD;
                        r_state   <= ST_GAP;
`ifdef HC138_SEL_TIMEOUT_EN
                        r_timeout <= w_req_sel;
`endif
                    end else begin
                        r_state <= ST_ACTIVE;
`ifdef HC138_SEL_TIMEOUT_EN
                        r_hold_cnt <= r_hold_cnt + 8'd1;
`endif
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == 4'd0) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_enable <= EN_OFF;
                    r_gnt    <= 8'h00;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.addr   = r_addr;
    assign bus.enable = r_enable;
    assign bus.gnt    = r_gnt;
    assign bus.busy   = r_busy;
`ifdef HC138_SEL_TIMEOUT_EN
    assign bus.timeout = r_timeout;
`else
    assign bus.timeout = 1'b0;
`endif

    hc138_sel_ctrl_chk #(
        .GAP_CYCLES (GAP_CYCLES),
        .HOLD_MAX   (HOLD_MAX)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (bus.addr),
        .enable  (bus.enable),
        .gnt     (bus.gnt),
        .busy    (bus.busy),
        .timeout (bus.timeout)
    );
endmodule

// Output invariants of the scheduler: legal enable codes, one-hot grant tied to addr,
// addr frozen while the decoder is enabled, single-cycle timeout pulse.
module hc138_sel_ctrl_chk #(
    parameter int GAP_CYCLES = 2,
    parameter int HOLD_MAX   = 16
) (
    input logic       clk,
    input logic       rst_n,
    input logic [2:0] addr,
    input logic [2:0] enable,
    input logic [7:0] gnt,
    input logic       busy,
    input logic       timeout
);
    localparam logic [2:0] EN_ON  = 3'b100;
    localparam logic [2:0] EN_OFF = 3'b011;

    a_param_range: assert property (@(posedge clk)
        (GAP_CYCLES >= 1) && (GAP_CYCLES <= 15) && (HOLD_MAX >= 1) && (HOLD_MAX <= 255));

    a_enable_code: assert property (@(posedge clk) disable iff (!rst_n)
        (enable == EN_ON) || (enable == EN_OFF));

    a_gnt_matches: assert property (@(posedge clk) disable iff (!rst_n)
        (enable == EN_ON) ? (gnt == (8'h01 << addr)) : (gnt == 8'h00));

    a_busy_on_grant: assert property (@(posedge clk) disable iff (!rst_n)
        (enable == EN_ON) |-> busy);

    a_addr_frozen: assert property (@(posedge clk) disable iff (!rst_n)
        (enable == EN_ON) |=> ((enable != EN_ON) || $stable(addr)));

    a_timeout_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        timeout |=> !timeout);
endmodule
